csa_resolve_48bit: RTL and testbench



---
 rtl/csa_pkg.sv | 17 +
 rtl/cpa_slice.sv | 28 ++
 rtl/full_adder.sv | 13 +
 rtl/csa_resolve_48bit.sv | 101 ++++++++++
 tb/tb_csa_resolve_48bit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-save resolver datapath.
package csa_pkg;

  localparam int unsigned WIDTH_48    = 48;
  localparam int unsigned SLICE_W_DEF = 12;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } csa_state_e;

  function automatic int unsigned nslice(input int unsigned width, input int unsigned slice_w);
    return width / slice_w;
  endfunction

endpackage

// File: rtl/cpa_slice.sv
// SLICE_W-bit ripple-carry adder built from a chain of full_adder cells.
module cpa_slice #(
  parameter int unsigned SLICE_W = 12
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csa_resolve_48bit.sv
// Sequential carry-propagate resolver: adds a latched (sum, carry) pair one slice per cycle,
// reusing a single slice adder and carrying between slices in a register.
module csa_resolve_48bit
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_48,
  parameter int unsigned SLICE_W = SLICE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] co_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int unsigned NSLICE = nslice(WIDTH, SLICE_W);
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  csa_state_e        state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;

  logic [SLICE_W-1:0] a_sl, b_sl, r_sl;
  logic               c_sl;
  logic               accept;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;

  assign a_sl = a_q[idx_q*SLICE_W +: SLICE_W];
  assign b_sl = b_q[idx_q*SLICE_W +: SLICE_W];

  cpa_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .cin (carry_q),
    .s   (r_sl),
    .cout(c_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            a_q     <= sum_in;
            b_q     <= co_in;
            idx_q   <= '0;
            carry_q <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          result[idx_q*SLICE_W +: SLICE_W] <= r_sl;
          carry_q <= c_sl;
          if (idx_q == LAST_IDX) begin
            carry_out <= c_sl;
            state_q   <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            if (in_valid) begin
              // Output handshake and new acceptance share this edge: no idle bubble.
              a_q     <= sum_in;
              b_q     <= co_in;
              idx_q   <= '0;
              carry_q <= 1'b0;
              state_q <= StBusy;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve_48bit.sv
// Self-checking bench for csa_resolve_48bit: directed cases plus randomized operand pairs
// checked against a 49-bit arithmetic reference.
module tb_csa_resolve_48bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] sum_in;
  logic [47:0] co_in;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] result;
  logic        carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csa_resolve_48bit u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_in   (sum_in),
    .co_in    (co_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry_out(carry_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rand48();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[47:0];
  endfunction

  function automatic logic [48:0] ref_sum(input logic [47:0] a, input logic [47:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge after the accepting edge.
  task automatic accept_pair(input logic [47:0] a, input logic [47:0] b);
    sum_in   = a;
    co_in    = b;
    in_valid = 1'b1;
    check_eq("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sum_in   = rand48();
    co_in    = rand48();
  endtask

  // Called at the negedge after acceptance; checks latency and the presented result.
  task automatic wait_result(input string tag, input logic [48:0] exp);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, "_lat"}, 64'(cyc), 64'd4);
    check_eq({tag, "_res"}, 64'({carry_out, result}), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [47:0] a, b, na, nb;
    logic [48:0] exp;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum_in    = '0;
    co_in     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_carry_out", 64'(carry_out), 64'd0);

    // Simple add
    accept_pair(48'h5, 48'h3);
    wait_result("simple", 49'h8);
    @(posedge clk);
    @(negedge clk);
    check_eq("simple_release", 64'(out_valid), 64'd0);

    // Carry crosses every slice boundary
    accept_pair(48'hFFFF_FFFF_FFFF, 48'h1);
    wait_result("ripple", 49'h1_0000_0000_0000);
    @(posedge clk);
    @(negedge clk);

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    accept_pair(48'h0123_4567_89AB, 48'h1111_1111_1110);
    wait_result("bp", 49'h0_1234_5678_9ABB);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_valid", 64'(out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_hold", 64'({carry_out, result}), 64'h0_1234_5678_9ABB);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_done_valid", 64'(out_valid), 64'd0);
    check_eq("bp_done_ready", 64'(in_ready), 64'd1);

    // Back-to-back: new pair accepted on the output handshake edge
    accept_pair(48'h8000_0000_0001, 48'h8000_0000_0001);
    wait_result("b2b1", 49'h1_0000_0000_0002);
    sum_in   = 48'h0000_0FFF_F000;
    co_in    = 48'h0000_0000_1000;
    in_valid = 1'b1;
    check_eq("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sum_in   = rand48();
    co_in    = rand48();
    check_eq("b2b_no_bubble", 64'(in_ready), 64'd0);
    wait_result("b2b2", 49'h0_0000_1000_0000);
    @(posedge clk);
    @(negedge clk);

    // Reset while slice 2 is being computed
    accept_pair(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_result", 64'(result), 64'd0);
    check_eq("mid_rst_carry", 64'(carry_out), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_discard", 64'(out_valid), 64'd0);
    accept_pair(48'h5, 48'h3);
    wait_result("post_rst", 49'h8);
    @(posedge clk);
    @(negedge clk);

    // Randomized pairs with random backpressure and random back-to-back offers
    a = rand48();
    b = rand48();
    accept_pair(a, b);
    out_ready = 1'($urandom());
    for (int i = 0; i < 1000; i++) begin
      exp = ref_sum(a, b);
      wait_result("rnd", exp);
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      check_eq("rnd_hold", 64'({out_valid, carry_out, result}), 64'({1'b1, exp}));
      out_ready = 1'b1;
      if (i == 999) begin
        @(posedge clk);
        @(negedge clk);
      end else begin
        na = rand48();
        nb = rand48();
        if ($urandom_range(0, 1) == 1) begin
          sum_in   = na;
          co_in    = nb;
          in_valid = 1'b1;
          @(posedge clk);
          @(negedge clk);
          in_valid = 1'b0;
          sum_in   = rand48();
          co_in    = rand48();
        end else begin
          @(posedge clk);
          @(negedge clk);
          accept_pair(na, nb);
        end
        a = na;
        b = nb;
        out_ready = 1'($urandom());
      end
    end
    check_eq("final_idle", 64'({in_ready, out_valid}), 64'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
